// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: instruction ROM port plus the IF/ID register outputs
// presented to decode. The fetch stage is the master; ROM/decode side is slave.
interface inst_fetch_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              rom_ce;
   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_inst;
   logic [ADDR_W-1:0] id_pc;
   logic [DATA_W-1:0] id_inst;
   logic              id_valid;
   logic              id_adel;

   modport master (
      output rom_ce, rom_addr, id_pc, id_inst, id_valid, id_adel,
      input  rom_inst
   );

   modport slave (
      input  rom_ce, rom_addr, id_pc, id_inst, id_valid, id_adel,
      output rom_inst
   );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC register with flush/stall/branch redirect,
// ROM enable, and the IF/ID pipeline register feeding decode.
module inst_fetch #(
   parameter int              ADDR_W   = 32,
   parameter int              DATA_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_pc,
   input  logic              stall_id,
   input  logic              flush,
   input  logic [ADDR_W-1:0] new_pc,
   input  logic              branch_flag,
   input  logic [ADDR_W-1:0] branch_target_addr,
   inst_fetch_if.master      bus
);

   logic              rom_ce;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] pc_next;
   logic [ADDR_W-1:0] id_pc;
   logic [DATA_W-1:0] id_inst;
   logic              id_valid;
   logic              id_adel;
   logic              hold;

   // stall_id alone freezes the PC as well, so nothing is lost or duplicated
   assign hold = stall_pc | stall_id;

   // ROM enable comes up on the first edge out of reset
   always_ff @(posedge clk) begin
      if (rst) rom_ce <= 1'b0;
      else     rom_ce <= 1'b1;
   end

   // next-PC priority: flush, then stall, then branch, then sequential (wraps)
   always_comb begin
      pc_next = pc + ADDR_W'(4);
      if (flush)            pc_next = new_pc;
      else if (hold)        pc_next = pc;
      else if (branch_flag) pc_next = branch_target_addr;
   end

   // PC stays parked at RESET_PC until the ROM is enabled
   always_ff @(posedge clk) begin
      if (rst || !rom_ce) pc <= RESET_PC;
      else                pc <= pc_next;
   end

   // IF/ID register: flush bubbles, stall_id holds, stall_pc bubbles, else capture
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         id_pc    <= '0;
         id_inst  <= '0;
         id_valid <= 1'b0;
         id_adel  <= 1'b0;
      end else if (stall_id) begin
         id_pc    <= id_pc;
         id_inst  <= id_inst;
         id_valid <= id_valid;
         id_adel  <= id_adel;
      end else if (stall_pc) begin
         id_pc    <= '0;
         id_inst  <= '0;
         id_valid <= 1'b0;
         id_adel  <= 1'b0;
      end else begin
         id_pc    <= pc;
         id_inst  <= bus.rom_inst;
         id_valid <= rom_ce;
         id_adel  <= (pc[1:0] != 2'b00);
      end
   end

   assign bus.rom_ce   = rom_ce;
   assign bus.rom_addr = pc;
   assign bus.id_pc    = id_pc;
   assign bus.id_inst  = id_inst;
   assign bus.id_valid = id_valid;
   assign bus.id_adel  = id_adel;

endmodule
